// File: rtl/count_sequence_checker_pkg.sv
// rtl/count_sequence_checker_pkg.sv - shared state encoding for the count sequence checker
package count_chk_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    UNLOCKED = 2'b00,
    SYNCING  = 2'b01,
    LOCKED   = 2'b10
  } chk_state_e;

endpackage

// File: rtl/count_sequence_checker_if.sv
// rtl/count_sequence_checker_if.sv - sample input and status output bundle of the checker
interface count_sequence_checker_if #(
  parameter int WIDTH     = 6,
  parameter int ERR_CNT_W = 16
);
  import count_chk_pkg::*;

  logic                 enable;
  logic [WIDTH-1:0]     count_in;
  logic                 clear;
  logic                 locked;
  logic                 mismatch;
  logic [WIDTH-1:0]     expected;
  logic [ERR_CNT_W-1:0] err_count;
  logic [STATE_W-1:0]   state;

  modport master (
    output enable, count_in, clear,
    input  locked, mismatch, expected, err_count, state
  );

  modport slave (
    input  enable, count_in, clear,
    output locked, mismatch, expected, err_count, state
  );

endinterface

// File: rtl/count_sequence_checker_sat_counter.sv
// rtl/count_sequence_checker_sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - locks onto an incrementing count stream and flags broken increments
module count_sequence_checker #(
  parameter int WIDTH     = 6,
  parameter int ERR_CNT_W = 16,
  parameter int SYNC_LEN  = 2,
  parameter int MAX_MISS  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  count_sequence_checker_if.slave bus
);
  import count_chk_pkg::*;

  localparam int RUN_W  = $clog2(SYNC_LEN + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  chk_state_e        state_q;
  logic [WIDTH-1:0]  last_q;
  logic [RUN_W-1:0]  run_q;
  logic [MISS_W-1:0] miss_q;
  logic              locked_q;
  logic              mismatch_q;
  logic [WIDTH-1:0]  expected_q;

  logic [WIDTH-1:0]  next_w;
  logic [RUN_W-1:0]  run_inc_w;
  logic [MISS_W-1:0] miss_inc_w;
  logic              hit_w;
  logic              err_inc_w;

  assign next_w     = last_q + WIDTH'(1);
  assign run_inc_w  = run_q + RUN_W'(1);
  assign miss_inc_w = miss_q + MISS_W'(1);
  assign hit_w      = (bus.count_in == next_w);
  assign err_inc_w  = bus.enable && !bus.clear && (state_q == LOCKED) && !hit_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      last_q     <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      expected_q <= '0;
    end else begin
      mismatch_q <= 1'b0;
      if (bus.clear) begin
        state_q  <= UNLOCKED;
        locked_q <= 1'b0;
        run_q    <= '0;
        miss_q   <= '0;
      end else begin
        case (state_q)
          UNLOCKED: begin
            if (bus.enable) begin
              last_q  <= bus.count_in;
              run_q   <= '0;
              state_q <= SYNCING;
            end
          end
          SYNCING: begin
            if (bus.enable) begin
              last_q <= bus.count_in;
              if (hit_w) begin
                run_q <= run_inc_w;
                if (run_inc_w == RUN_W'(SYNC_LEN)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  miss_q   <= '0;
                end
              end else begin
                run_q <= '0;
              end
            end
          end
          LOCKED: begin
            if (bus.enable) begin
              if (hit_w) begin
                last_q <= bus.count_in;
                miss_q <= '0;
              end else begin
                // Flywheel on the prediction so one corrupted sample costs one mismatch
                mismatch_q <= 1'b1;
                expected_q <= next_w;
                last_q     <= next_w;
                miss_q     <= miss_inc_w;
                if (miss_inc_w == MISS_W'(MAX_MISS)) begin
                  state_q  <= UNLOCKED;
                  locked_q <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .inc_i   (err_inc_w),
    .clr_i   (bus.clear),
    .count_o (bus.err_count)
  );

  assign bus.locked   = locked_q;
  assign bus.mismatch = mismatch_q;
  assign bus.expected = expected_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed bench for count_sequence_checker
module tb_count_sequence_checker;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  count_sequence_checker_if #(.WIDTH(6), .ERR_CNT_W(16)) a_if ();
  count_sequence_checker_if #(.WIDTH(6), .ERR_CNT_W(4))  b_if ();

  count_sequence_checker #(
    .WIDTH(6), .ERR_CNT_W(16), .SYNC_LEN(2), .MAX_MISS(3)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if.slave)
  );

  count_sequence_checker #(
    .WIDTH(6), .ERR_CNT_W(4), .SYNC_LEN(2), .MAX_MISS(255)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic samp_a(input logic en, input logic [5:0] cin, input logic clr);
    a_if.enable   = en;
    a_if.count_in = cin;
    a_if.clear    = clr;
    @(posedge clock);
    #1;
    a_if.enable = 1'b0;
    a_if.clear  = 1'b0;
  endtask

  task automatic samp_b(input logic en, input logic [5:0] cin, input logic clr);
    b_if.enable   = en;
    b_if.count_in = cin;
    b_if.clear    = clr;
    @(posedge clock);
    #1;
    b_if.enable = 1'b0;
    b_if.clear  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    a_if.enable = 1'b0; a_if.count_in = '0; a_if.clear = 1'b0;
    b_if.enable = 1'b0; b_if.count_in = '0; b_if.clear = 1'b0;

    #2;
    chk("rst_state",    a_if.state,     0);
    chk("rst_locked",   a_if.locked,    0);
    chk("rst_mismatch", a_if.mismatch,  0);
    chk("rst_expected", a_if.expected,  0);
    chk("rst_err",      a_if.err_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Acquisition: 5,6,7
    samp_a(1, 5, 0); chk("acq_s1_state", a_if.state, 1);
    samp_a(1, 6, 0); chk("acq_s2_state", a_if.state, 1);
    chk("acq_s2_locked", a_if.locked, 0);
    samp_a(1, 7, 0); chk("acq_s3_state", a_if.state, 2);
    chk("acq_s3_locked", a_if.locked, 1);
    chk("acq_err", a_if.err_count, 0);

    // Wrap-around accepted
    samp_a(0, 0, 1); chk("clr1_state", a_if.state, 0);
    samp_a(1, 58, 0); samp_a(1, 59, 0); samp_a(1, 60, 0);
    chk("wrap_lock", a_if.locked, 1);
    samp_a(1, 61, 0); chk("wrap61_mm", a_if.mismatch, 0);
    samp_a(1, 62, 0); chk("wrap62_mm", a_if.mismatch, 0);
    samp_a(1, 63, 0); chk("wrap63_mm", a_if.mismatch, 0);
    samp_a(1, 0, 0);  chk("wrap0_mm",  a_if.mismatch, 0);
    samp_a(1, 1, 0);  chk("wrap1_mm",  a_if.mismatch, 0);
    chk("wrap_locked", a_if.locked, 1);
    chk("wrap_err", a_if.err_count, 0);

    // Single corrupted sample
    samp_a(0, 0, 1);
    samp_a(1, 8, 0); samp_a(1, 9, 0); samp_a(1, 10, 0);
    samp_a(1, 11, 0); chk("one11_mm", a_if.mismatch, 0);
    samp_a(1, 40, 0); chk("one40_mm", a_if.mismatch, 1);
    chk("one40_exp", a_if.expected, 12);
    samp_a(1, 13, 0); chk("one13_mm", a_if.mismatch, 0);
    samp_a(1, 14, 0); chk("one14_mm", a_if.mismatch, 0);
    chk("one_err", a_if.err_count, 1);
    chk("one_locked", a_if.locked, 1);

    // Three consecutive misses drop lock
    samp_a(0, 0, 1); chk("clr2_err", a_if.err_count, 0);
    samp_a(1, 18, 0); samp_a(1, 19, 0); samp_a(1, 20, 0);
    samp_a(1, 0, 0); chk("loss1_mm", a_if.mismatch, 1); chk("loss1_exp", a_if.expected, 21);
    chk("loss1_locked", a_if.locked, 1);
    samp_a(1, 0, 0); chk("loss2_mm", a_if.mismatch, 1); chk("loss2_exp", a_if.expected, 22);
    samp_a(1, 0, 0); chk("loss3_mm", a_if.mismatch, 1); chk("loss3_exp", a_if.expected, 23);
    chk("loss_err", a_if.err_count, 3);
    chk("loss_locked", a_if.locked, 0);
    chk("loss_state", a_if.state, 0);

    // Idle cycles while locked, then a miss, then clear with a sample
    samp_a(1, 30, 0); samp_a(1, 31, 0); samp_a(1, 32, 0);
    chk("idle_pre_state", a_if.state, 2);
    for (int i = 0; i < 10; i++) samp_a(0, 6'(i), 0);
    chk("idle_state",  a_if.state,     2);
    chk("idle_locked", a_if.locked,    1);
    chk("idle_mm",     a_if.mismatch,  0);
    chk("idle_err",    a_if.err_count, 3);
    samp_a(1, 50, 0); chk("pre_clr_mm", a_if.mismatch, 1); chk("pre_clr_exp", a_if.expected, 33);
    chk("pre_clr_err", a_if.err_count, 4);
    samp_a(0, 0, 0); chk("dis_mm_drop", a_if.mismatch, 0);
    samp_a(1, 50, 0); chk("pre_clr2_mm", a_if.mismatch, 1);
    samp_a(1, 6'(99 & 63), 1);
    chk("clr_state",  a_if.state,     0);
    chk("clr_err",    a_if.err_count, 0);
    chk("clr_mm",     a_if.mismatch,  0);
    chk("clr_locked", a_if.locked,    0);

    // Saturation on the narrow error counter
    samp_b(1, 0, 0); samp_b(1, 1, 0); samp_b(1, 2, 0);
    chk("sat_lock", b_if.locked, 1);
    for (int i = 0; i < 15; i++) samp_b(1, 40, 0);
    chk("sat_15", b_if.err_count, 15);
    for (int i = 0; i < 5; i++) samp_b(1, 40, 0);
    chk("sat_20", b_if.err_count, 15);
    chk("sat_locked", b_if.locked, 1);
    chk("sat_exp", b_if.expected, 22);

    // Asynchronous reset mid-stream
    samp_a(1, 4, 0); samp_a(1, 5, 0); samp_a(1, 6, 0);
    samp_a(1, 9, 0);
    chk("arst_pre_mm", a_if.mismatch, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state",    a_if.state,     0);
    chk("arst_locked",   a_if.locked,    0);
    chk("arst_mm",       a_if.mismatch,  0);
    chk("arst_exp",      a_if.expected,  0);
    chk("arst_err",      a_if.err_count, 0);
    chk("arst_b_err",    b_if.err_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    samp_a(1, 8, 0); chk("reacq_state", a_if.state, 1);
    samp_a(1, 9, 0); samp_a(1, 10, 0);
    chk("reacq_locked", a_if.locked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
